// File: rtl/prog_clk_div_pkg.sv
// rtl/prog_clk_div_pkg.sv - shared mode encoding and ratio helpers for the programmable clock divider
package prog_clk_div_pkg;

    typedef enum logic [1:0] {
        DUTY50   = 2'b00,
        PULSE_HI = 2'b01,
        PULSE_LO = 2'b10,
        RSVD     = 2'b11
    } clk_div_mode_e;

    // Helpers work at a fixed wide width so callers of any WIDTH can use them
    localparam int unsigned CALC_W = 32;

    // Ratios below 2 cannot form a period with both a high and a low phase
    function automatic logic [CALC_W-1:0] clamp_div(input logic [CALC_W-1:0] d);
        return (d < CALC_W'(2)) ? CALC_W'(2) : d;
    endfunction

    // Number of cycles clk_out stays high within one period of length d
    function automatic logic [CALC_W-1:0] high_len(input logic [CALC_W-1:0] d,
                                                   input clk_div_mode_e     mode);
        logic [CALC_W-1:0] h;
        case (mode)
            PULSE_HI: h = CALC_W'(1);
            PULSE_LO: h = d - CALC_W'(1);
            default:  h = (d + CALC_W'(1)) >> 1;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// rtl/prog_clk_divider_if.sv - control/load/output bundle of the programmable clock divider
interface prog_clk_divider_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] div_in;
    logic [1:0]       mode_in;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [WIDTH-1:0] div_active;

    // Side that requests ratios and consumes the divided clock
    modport master (
        output en, load_valid, div_in, mode_in,
        input  load_ready, clk_out, tick, running, div_active
    );

    // Divider side
    modport slave (
        input  en, load_valid, div_in, mode_in,
        output load_ready, clk_out, tick, running, div_active
    );
endinterface

// File: rtl/prog_clk_div_shadow.sv
// rtl/prog_clk_div_shadow.sv - single-entry valid/ready holding register for a pending ratio/mode
module prog_clk_div_shadow
    import prog_clk_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_div_in,
    input  logic [1:0]       i_mode_in,
    input  logic             i_apply,
    output logic [WIDTH-1:0] o_pending_div,
    output clk_div_mode_e    o_pending_mode,
    output logic             o_pending_valid
);

    logic             r_valid;
    logic [WIDTH-1:0] r_div;
    clk_div_mode_e    r_mode;
    logic             w_accept;

    // Only an empty shadow accepts, so accept and apply never coincide
    assign w_accept = i_load_valid & ~r_valid;

    // Capture on accept, empty when the divider consumes the entry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_div   <= '0;
            r_mode  <= DUTY50;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_div   <= i_div_in;
            r_mode  <= clk_div_mode_e'(i_mode_in);
        end else if (i_apply) begin
            r_valid <= 1'b0;
        end
    end

    assign o_load_ready    = ~r_valid;
    assign o_pending_div   = r_div;
    assign o_pending_mode  = r_mode;
    assign o_pending_valid = r_valid;

endmodule

// File: rtl/prog_clk_divider.sv
// rtl/prog_clk_divider.sv - programmable integer clock divider with glitch-free ratio reload
module prog_clk_divider
    import prog_clk_div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    prog_clk_divider_if.slave  bus_if
);

    localparam logic [WIDTH-1:0] RESET_DIV_W = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);

    logic [WIDTH-1:0]  r_cnt;
    logic              r_running;
    logic [WIDTH-1:0]  r_div;
    clk_div_mode_e     r_mode;
    logic              r_clk_out;
    logic              r_tick;

    logic [WIDTH-1:0]  w_pend_div;
    clk_div_mode_e     w_pend_mode;
    logic              w_pend_valid;
    logic              w_load_ready;
    logic              w_wrap;
    logic              w_apply;
    logic [WIDTH-1:0]  w_cnt_nxt;
    logic              w_run_nxt;
    logic [WIDTH-1:0]  w_div_nxt;
    clk_div_mode_e     w_mode_nxt;
    logic [CALC_W-1:0] w_high_nxt;
    logic              w_clk_nxt;
    logic              w_tick_nxt;

    prog_clk_div_shadow #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_load_valid    (bus_if.load_valid),
        .o_load_ready    (w_load_ready),
        .i_div_in        (bus_if.div_in),
        .i_mode_in       (bus_if.mode_in),
        .i_apply         (w_apply),
        .o_pending_div   (w_pend_div),
        .o_pending_mode  (w_pend_mode),
        .o_pending_valid (w_pend_valid)
    );

    // Next-state of counter/run flag and ratio; a new ratio only lands on a period boundary
    always_comb begin
        w_wrap    = r_running && (r_cnt == (r_div - CNT_ONE));
        w_apply   = w_pend_valid && (!r_running || w_wrap);
        w_run_nxt = 1'b1;
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (!r_running || w_wrap) begin
            w_run_nxt = bus_if.en;
            w_cnt_nxt = '0;
        end
        w_div_nxt  = r_div;
        w_mode_nxt = r_mode;
        if (w_apply) begin
            w_div_nxt  = WIDTH'(clamp_div(CALC_W'(w_pend_div)));
            w_mode_nxt = w_pend_mode;
        end
    end

    // Output decode from next-state so clk_out/tick are registered without extra latency
    always_comb begin
        w_high_nxt = high_len(CALC_W'(w_div_nxt), w_mode_nxt);
        w_clk_nxt  = w_run_nxt && (CALC_W'(w_cnt_nxt) < w_high_nxt);
        w_tick_nxt = w_run_nxt && (w_cnt_nxt == '0);
    end

    // State and output registers; reset abandons any partial period immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_div     <= RESET_DIV_W;
            r_mode    <= DUTY50;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_running <= w_run_nxt;
            r_div     <= w_div_nxt;
            r_mode    <= w_mode_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign bus_if.load_ready = w_load_ready;
    assign bus_if.clk_out    = r_clk_out;
    assign bus_if.tick       = r_tick;
    assign bus_if.running    = r_running;
    assign bus_if.div_active = r_div;

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
Programmable integer clock divider. It is the parametrised successor to the team's simple terminal-count divider. It adds:
- a selectable output waveform mode,
- a valid/ready load handshake whose new ratio takes effect only at a period boundary, so there are no runt pulses,
- a clean stop/start enable,
- a one-cycle period strobe for downstream logic.

It sits beside the clock-generation logic. It produces a registered divided clock (clk_out) and a clock-enable pulse (tick), both in the clk domain.

Parameters:
WIDTH, 8, width of divide ratio and period counter
RESET_DIV, 16, divide ratio loaded at reset (must be >= 2 and < 2**WIDTH)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous and active-high
en  input  1  run request
load_valid  input  1  new ratio/mode offered
load_ready  output  1  shadow register empty; load accepted when load_valid & load_ready
div_in  input  WIDTH  requested divide ratio D
mode_in  input  2  requested waveform mode
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle strobe at the start of each period
running  output  1  divider currently producing periods
div_active  output  WIDTH  ratio currently in effect, after clamping

Behaviour:
Reset values (asserted asynchronously):
- cnt=0; div_active=RESET_DIV; mode=DUTY50; shadow empty.
- load_ready=1, clk_out=0, tick=0, running=0.
- A reset asserted mid-period takes effect immediately; there is no period completion.

Ratio clamp:
- Ratios D<2 are clamped to 2 when they become active. div_active reports the clamped value.

Modes and high time H:
- 00 DUTY50: H=(D+1)>>1, high-biased for odd D.
- 01 PULSE_HI: H=1.
- 10 PULSE_LO: H=D-1.
- 11 reserved: behaves exactly as DUTY50.

Registered outputs:
- All outputs are registered and decoded from next-state values.
- clk_out = running & (cnt < H).
- tick = running & (cnt == 0).

Start:
- When running=0 and en=1 at an edge, the next edge gives running=1, cnt=0, clk_out=1, tick=1.
- First tick therefore appears 1 cycle after en is sampled high.

Counting:
- Each edge while running: cnt increments.
- At cnt==D-1 (the wrap edge):
  - if en=1: cnt returns to 0 and a new period starts.
  - if en=0: running=0, cnt=0, clk_out=0, tick=0.
- Deasserting en never truncates a period. The current period always completes.

Load handshake:
- At an accepting edge, div_in and mode_in are captured into the shadow register and load_ready falls.
- The shadow is applied to div_active/mode at the first subsequent wrap edge, or at the next edge if running=0.
- On application, the shadow empties and load_ready rises at that same edge.
- A load accepted on a wrap edge is not applied at that wrap; it is applied at the following wrap.
- load_valid while load_ready=0 is ignored, and the offer stays pending until ready rises.

Start and apply on the same edge:
- If a start and a shadow application coincide (running=0), the new ratio governs the first period.

Width:
- cnt is WIDTH bits and never exceeds D-1, so there is no overflow.

Decomposition:
Package prog_clk_div_pkg contains:
- typedef enum logic [1:0] clk_div_mode_e {DUTY50, PULSE_HI, PULSE_LO, RSVD}.
- Function clamp_div(D): returns max(D,2).
- Function high_len(D, mode).

Sub-module prog_clk_div_shadow holds the valid/ready shadow register. Its interface is:
- load_valid and load_ready on the input side,
- an apply strobe from the main block,
- pending_div, pending_mode and pending_valid as outputs.

Counter, start/stop control and output decode stay in prog_clk_divider.

Test Plan:
1. After reset, en=1, RESET_DIV=16:
   - tick appears 1 cycle after en and then every 16 cycles.
   - clk_out is high 8 cycles and low 8 cycles.
   - div_active=16.
2. Load D=5, mode 00 at cnt=3:
   - load_ready=0 until the 16-period wraps, then rises on the wrap edge.
   - Subsequent periods are 5 cycles, high 3 and low 2. No period is shorter than 5 or 16.
3. Load D=0 (also D=1) while stopped:
   - div_active=2 on the next edge.
   - After en, clk_out toggles every cycle and tick fires every 2 cycles.
4. Mode 01 D=4: clk_out high 1 of 4 cycles, coincident with tick. Mode 10 D=4: clk_out low only at cnt=3.
5. D=10, drop en at cnt=3:
   - Counting continues to cnt=9, then running=0 and clk_out=0.
   - Re-asserting en restarts at cnt=0 with a tick.
6. Assert rst at cnt=7 with a load pending:
   - clk_out, tick and running go to 0 immediately.
   - load_ready=1 and div_active=16.
   - The pending load is discarded.
